// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small character FIFO drained by a serialiser FSM.
// Busy_o/Empty_o depend only on registered state, so an upstream block may derive its strobe from ~Busy_o.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        Data_i,
  input  logic              Trans_i,
  output logic              Busy_o,
  output logic              Empty_o,
  output logic              Tx_o,
  output logic [ADDR_W:0]   Level_o,
  output logic              Ovf_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;
  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;

  logic w_full, w_has_data, w_push, w_pop, w_baud_end;

  assign w_full     = (r_level == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_has_data = (r_level != '0);
  assign w_push     = Trans_i && !w_full;
  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  assign Busy_o  = w_full;
  assign Empty_o = !w_has_data && (r_state == S_IDLE);
  assign Tx_o    = r_tx;
  assign Level_o = r_level;
  assign Ovf_o   = r_ovf;

  // Tx level is computed here for the state being entered, so the line register changes exactly on the entry edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + BAUD_W'(1);
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= Data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + (ADDR_W+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (ADDR_W+1)'(1);
      if (Trans_i && w_full) r_ovf <= 1'b1;
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-count reference model plus a frame-decoding monitor fed by a byte scoreboard.
module tb_uart_tx_fifo;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    Data_i = '0;
  logic          Trans_i = 1'b0;
  logic          Busy_o, Empty_o, Tx_o, Ovf_o;
  logic [AW:0]   Level_o;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .Data_i(Data_i), .Trans_i(Trans_i),
    .Busy_o(Busy_o), .Empty_o(Empty_o), .Tx_o(Tx_o), .Level_o(Level_o), .Ovf_o(Ovf_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: queue of buffered bytes plus a countdown of cycles left in the current frame.
  logic [7:0] mfifo[$];
  logic [7:0] sb_q[$];
  int         busy_cnt = 0;
  logic [7:0] cur = '0;
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int sz;
    bit acc;
    if (rst) begin
      mfifo.delete();
      sb_q.delete();
      busy_cnt = 0;
      m_ovf    = 1'b0;
    end else begin
      sz  = mfifo.size();
      acc = Trans_i && (sz < D);
      if (Trans_i && sz == D) m_ovf = 1'b1;
      if (sz != 0 && busy_cnt <= 1) begin
        cur      = mfifo.pop_front();
        busy_cnt = 10 * C;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (acc) begin
        mfifo.push_back(Data_i);
        sb_q.push_back(Data_i);
      end
    end
  end

  function automatic int exp_tx();
    int idx;
    if (busy_cnt == 0) return 1;
    idx = (10 * C - busy_cnt) / C;
    if (idx == 0) return 0;
    if (idx == 9) return 1;
    return int'(cur[idx-1]);
  endfunction

  always @(negedge clk) begin
    chk("level", int'(Level_o), mfifo.size());
    chk("busy",  int'(Busy_o),  int'(mfifo.size() == D));
    chk("empty", int'(Empty_o), int'(mfifo.size() == 0 && busy_cnt == 0));
    chk("ovf",   int'(Ovf_o),   int'(m_ovf));
    chk("tx",    int'(Tx_o),    exp_tx());
  end

  // Monitor: find the start bit, sample each bit mid-period, compare the byte with the scoreboard head.
  int         mcnt = -1;
  logic [9:0] frm;
  always @(negedge clk) begin
    if (rst) begin
      mcnt = -1;
    end else begin
      if (mcnt < 0 && Tx_o == 1'b0) mcnt = 0;
      else if (mcnt >= 0) mcnt++;
      if (mcnt >= 0 && (mcnt % C) == C / 2) begin
        frm[mcnt / C] = Tx_o;
        if (mcnt / C == 9) begin
          chk("start_bit", int'(frm[0]), 0);
          chk("stop_bit",  int'(frm[9]), 1);
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", frm[8:1], $time);
          end else begin
            chk("byte", int'(frm[8:1]), int'(sb_q.pop_front()));
          end
          mcnt = -1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] d);
    Trans_i = 1'b1;
    Data_i  = d;
    @(negedge clk);
    Trans_i = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_tx",    int'(Tx_o),    1);
    chk("rst_level", int'(Level_o), 0);
    chk("rst_empty", int'(Empty_o), 1);
    chk("rst_busy",  int'(Busy_o),  0);
    chk("rst_ovf",   int'(Ovf_o),   0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while (!(mfifo.size() == 0 && busy_cnt == 0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got level %0d expected 0", Level_o);
    end
    cyc(3);
    chk("drain_empty", int'(Empty_o), 1);
    chk("drain_level", int'(Level_o), 0);
  endtask

  task automatic hs(input int n, input bit inc, input logic [7:0] base);
    int i = 0;
    int g = 0;
    while (i < n && g < 5000) begin
      if (!Busy_o && $urandom_range(0, 3) != 0) begin
        Trans_i = 1'b1;
        Data_i  = inc ? base + 8'(i) : 8'($urandom);
        i++;
      end else begin
        Trans_i = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    Trans_i = 1'b0;
    if (i < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL hs_timeout: got %0d bytes expected %0d", i, n);
    end
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    @(negedge clk);

    put(8'hA5);
    chk("a5_empty_low", int'(Empty_o), 0);
    drain();

    for (int i = 1; i <= 6; i++) put(8'(i));
    chk("six_ovf", int'(Ovf_o), 1);
    drain();
    chk("ovf_sticky", int'(Ovf_o), 1);

    do_reset();
    hs(12, 1'b0, 8'h00);
    drain();
    chk("hs_ovf", int'(Ovf_o), 0);

    put(8'h11);
    cyc(40);
    put(8'h3C);
    drain();

    put(8'h01);
    put(8'h02);
    put(8'h03);
    cyc(16);
    do_reset();
    put(8'h5A);
    drain();

    do_reset();
    hs(3 * D + 1, 1'b1, 8'h20);
    drain();
    chk("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
